// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_GAP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Total bit times in one frame, start bit through last stop bit.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned stop_bits,
                                               input bit          parity_en);
        return 32'd1 + data_bits + (parity_en ? 32'd1 : 32'd0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with push/pop, occupancy count and async active-high reset.
module uart_tx_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [width-1:0]             push_data,
    input  logic                         pop,
    output logic [width-1:0]             pop_data,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(depth));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with TX FIFO and post-message idle gap.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned cycles_per_bit  = 4,
    parameter int unsigned data_bits       = 8,
    parameter int unsigned stop_bits       = 1,
    parameter int unsigned extra_stop_bits = 7,
    parameter int unsigned fifo_depth      = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [data_bits-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              parity_odd,
    output logic                              serial,
    output logic                              busy,
    output logic                              idle,
    output logic [$clog2(fifo_depth+1)-1:0]   fifo_count
);

    localparam int unsigned DLY_W   = $clog2(cycles_per_bit);
    localparam int unsigned IDX_MAX =
        (data_bits > stop_bits)
            ? ((data_bits > extra_stop_bits) ? data_bits : extra_stop_bits)
            : ((stop_bits > extra_stop_bits) ? stop_bits : extra_stop_bits);
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    tx_state_t            state;
    logic [DLY_W-1:0]     bit_delay;
    logic [IDX_W-1:0]     bit_index;
    logic [data_bits-1:0] shreg;
    logic [data_bits-1:0] pop_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;

`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign bit_end   = (bit_delay == DLY_W'(cycles_per_bit - 1));
    assign last_stop = (bit_index == IDX_W'(stop_bits - 1));

    uart_tx_fifo #(
        .width (data_bits),
        .depth (fifo_depth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pop points: from IDLE at once, otherwise only on a bit boundary.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: pop = bit_end && last_stop && !fifo_empty;
            ST_GAP:  pop = bit_end && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_delay <= '0;
            bit_index <= '0;
            shreg     <= '0;
            serial    <= 1'b1;
            busy      <= 1'b0;
            idle      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= PARITY_EVEN;
`endif
        end else if (pop) begin
            state     <= ST_START;
            bit_delay <= '0;
            bit_index <= '0;
            shreg     <= pop_data;
            serial    <= 1'b0;
            busy      <= 1'b1;
            idle      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^pop_data) ^ parity_odd;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    idle <= !push;
                end
                ST_START: begin
                    if (bit_end) begin
                        state     <= ST_DATA;
                        bit_delay <= '0;
                        bit_index <= '0;
                        serial    <= shreg[0];
                        shreg     <= shreg >> 1;
                    end else begin
                        bit_delay <= bit_delay + DLY_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_delay <= '0;
                        if (bit_index == IDX_W'(data_bits - 1)) begin
                            bit_index <= '0;
`ifdef UART_TX_PARITY_EN
                            state  <= ST_PARITY;
                            serial <= parity_bit;
`else
                            state  <= ST_STOP;
                            serial <= 1'b1;
`endif
                        end else begin
                            bit_index <= bit_index + IDX_W'(1);
                            serial    <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end else begin
                        bit_delay <= bit_delay + DLY_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state     <= ST_STOP;
                        bit_delay <= '0;
                        bit_index <= '0;
                        serial    <= 1'b1;
                    end else begin
                        bit_delay <= bit_delay + DLY_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        bit_delay <= '0;
                        if (last_stop) begin
                            // FIFO is empty here, otherwise pop would have restarted.
                            bit_index <= '0;
                            busy      <= 1'b0;
                            if (extra_stop_bits == 0) begin
                                state <= ST_IDLE;
                                idle  <= !push;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            bit_index <= bit_index + IDX_W'(1);
                        end
                    end else begin
                        bit_delay <= bit_delay + DLY_W'(1);
                    end
                end
                ST_GAP: begin
                    if (bit_end) begin
                        bit_delay <= '0;
                        if (bit_index == IDX_W'(extra_stop_bits - 1)) begin
                            state     <= ST_IDLE;
                            bit_index <= '0;
                            idle      <= !push;
                        end else begin
                            bit_index <= bit_index + IDX_W'(1);
                        end
                    end else begin
                        bit_delay <= bit_delay + DLY_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    serial <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: vector table, line monitor and scoreboard.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 1 + 8 + PAR + 1;
    localparam int FCLK  = FRAME * 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       parity_odd;
    logic       serial;
    logic       busy;
    logic       idle;
    logic [2:0] fifo_count;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       podd;
    } exp_t;
    exp_t exp_q[$];
    int   start_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        podd;
        logic [0:10] seq;
        int          busy_fall;
        int          idle_rise;
    } vec_t;
    vec_t vecs [4];

    uart_tx_param dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .parity_odd (parity_odd),
        .serial     (serial),
        .busy       (busy),
        .idle       (idle),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Caller sits on a negedge; the push lands on the following rising edge.
    task automatic push_now(input logic [7:0] d, input logic po, output int edge_n);
        in_data    = d;
        parity_odd = po;
        in_valid   = 1'b1;
        @(negedge clock);
        edge_n   = cyc;
        in_valid = 1'b0;
        exp_q.push_back({d, po});
    endtask

    // Line monitor: decodes every frame from serial and checks it against the scoreboard.
    logic mon_s [FCLK];
    logic mon_on = 1'b0;
    int   mon_t  = 0;
    always @(negedge clock) begin
        if (reset) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (serial == 1'b0) begin
                mon_on   = 1'b1;
                mon_s[0] = serial;
                mon_t    = 1;
                start_q.push_back(cyc);
            end
        end else begin
            mon_s[mon_t] = serial;
            mon_t++;
            if (mon_t == FCLK) begin
                logic [7:0] d;
                logic       hold_ok;
                exp_t       e;
                mon_on  = 1'b0;
                hold_ok = 1'b1;
                for (int b = 0; b < FRAME; b++)
                    for (int j = 1; j < 4; j++)
                        if (mon_s[b*4+j] !== mon_s[b*4]) hold_ok = 1'b0;
                for (int i = 0; i < 8; i++) d[i] = mon_s[(1+i)*4];
                check("bit_hold", int'(hold_ok), 1);
                check("stop_bit", int'(mon_s[(FRAME-1)*4]), 1);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", int'(d), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", int'(d), int'(e.data));
`ifdef UART_TX_PARITY_EN
                    check("frame_parity", int'(mon_s[9*4]), int'((^e.data) ^ e.podd));
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, s, t, bf, ir, base, run, maxrun, idle_seen, nstart, low_seen;
        logic [0:10] obs;
        logic rdy;
        int acc [7];

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h07, 1'b0, 11'b01110000011, 44, 72};
        vecs[1] = '{8'h07, 1'b1, 11'b01110000001, 44, 72};
        vecs[2] = '{8'hA5, 1'b0, 11'b01010010101, 44, 72};
        vecs[3] = '{8'h00, 1'b1, 11'b00000000011, 44, 72};
`else
        vecs[0] = '{8'hA5, 1'b0, 11'b01010010111, 40, 68};
        vecs[1] = '{8'h3C, 1'b1, 11'b00011110011, 40, 68};
        vecs[2] = '{8'h00, 1'b0, 11'b00000000011, 40, 68};
        vecs[3] = '{8'hFF, 1'b1, 11'b01111111111, 40, 68};
`endif

        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        parity_odd = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_serial", int'(serial), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_fifo_count", int'(fifo_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single-frame vectors: waveform and busy/idle timing from the start edge.
        for (int v = 0; v < 4; v++) begin
            push_now(vecs[v].data, vecs[v].podd, p);
            s = p + 1; bf = -1; ir = -1; obs = '1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clock);
                t = cyc - s;
                if (t == 0) parity_odd = ~vecs[v].podd;
                if ((t % 4) == 1 && (t / 4) < 11) obs[t/4] = serial;
                if (t > 0 && bf < 0 && busy == 1'b0) bf = t;
                if (ir < 0 && idle == 1'b1) ir = t;
            end
            check($sformatf("vec%0d_serial", v), int'(obs), int'(vecs[v].seq));
            check($sformatf("vec%0d_busy_fall", v), bf, vecs[v].busy_fall);
            check($sformatf("vec%0d_idle_rise", v), ir, vecs[v].idle_rise);
        end

        // Back-to-back frames.
        base = start_q.size();
        in_data = 8'h55; parity_odd = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        exp_q.push_back({8'h55, 1'b0});
        in_data = 8'h0F;
        @(negedge clock);
        exp_q.push_back({8'h0F, 1'b0});
        in_valid = 1'b0;
        run = 0; maxrun = 0;
        for (int k = 0; k < 2 * FCLK + 10; k++) begin
            @(negedge clock);
            if (start_q.size() == base + 1) begin
                if (serial) run++; else run = 0;
                if (run > maxrun) maxrun = run;
            end
        end
        if (start_q.size() >= base + 2)
            check("b2b_spacing", start_q[base+1] - start_q[base], FCLK);
        else
            check("b2b_starts", start_q.size() - base, 2);
        check("b2b_max_high", maxrun, 4);
        repeat (80) @(negedge clock);

        // FIFO full: hold valid for six words.
        for (int w = 1; w <= 6; w++) begin
            bit ok;
            in_data = 8'(w); parity_odd = 1'b0; in_valid = 1'b1; ok = 1'b0;
            for (int k = 0; k < 200 && !ok; k++) begin
                rdy = in_ready;
                @(negedge clock);
                if (rdy) begin
                    ok = 1'b1;
                    acc[w] = cyc;
                    exp_q.push_back({8'(w), 1'b0});
                end
            end
            check($sformatf("full_accept%0d", w), int'(ok), 1);
            if (w == 5) begin
                check("full_fifo_count", int'(fifo_count), 4);
                check("full_in_ready", int'(in_ready), 0);
            end
        end
        in_valid = 1'b0;
        check("full_word6_edge", acc[6] - acc[1], 1 + FCLK + 1);
        for (int k = 0; k < 6 * FCLK + 100 && exp_q.size() != 0; k++) @(negedge clock);
        check("full_all_sent", exp_q.size(), 0);
        repeat (80) @(negedge clock);

        // Gap interrupt at GAP bit 2.
        base = start_q.size();
        @(negedge clock);
        push_now(8'h81, 1'b0, p);
        s = p + 1;
        idle_seen = 0;
        while (cyc < s + 49) begin
            @(negedge clock);
            if (idle) idle_seen++;
        end
        push_now(8'h42, 1'b1, p);
        check("gap_push_edge", p - s, 50);
        for (int k = 0; k < FCLK + 10; k++) begin
            @(negedge clock);
            if (idle) idle_seen++;
        end
        check("gap_idle_never", idle_seen, 0);
        if (start_q.size() >= base + 2)
            check("gap_restart", start_q[base+1] - s, 52);
        else
            check("gap_starts", start_q.size() - base, 2);
        repeat (80) @(negedge clock);

        // Reset during data bit 3 with two words queued.
        @(negedge clock);
        push_now(8'hC3, 1'b0, p);
        push_now(8'h5A, 1'b0, t);
        push_now(8'h96, 1'b0, t);
        check("mid_fifo_count", int'(fifo_count), 2);
        s = p + 1;
        while (cyc < s + 17) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_serial", int'(serial), 1);
        check("mid_rst_fifo_count", int'(fifo_count), 0);
        check("mid_rst_idle", int'(idle), 1);
        check("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        nstart = start_q.size();
        low_seen = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clock);
            if (!serial) low_seen++;
        end
        check("mid_no_tx_after", start_q.size() - nstart, 0);
        check("mid_line_high", low_seen, 0);
        check("mid_idle_after", int'(idle), 1);
        check("end_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It has configurable clocks-per-bit, data width, stop-bit count and inter-message idle gap. A small transmit FIFO with a valid/ready push interface lets software-side logic queue bytes back-to-back. It sits between the system core and the serial pin, and pairs with the existing UART receiver.

Parameters:
cycles_per_bit, 4, clocks per serial bit; legal range is 2 or more.
data_bits, 8, data bits per frame; legal range is 5..9; sent LSB first.
stop_bits, 1, stop bits per frame; 1 or 2.
extra_stop_bits, 7, additional idle-high bit times after the last queued frame, so the receiver can resynchronise.
fifo_depth, 4, TX FIFO entries; a power of two and at least 2.

Ports:
clock  input  1  global clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_data  input  data_bits  byte to queue.
in_valid  input  1  push request.
in_ready  output  1  FIFO not full; a push happens when in_valid && in_ready at a rising edge.
parity_odd  input  1  parity select: 1 = odd, 0 = even. Used only when UART_TX_PARITY_EN is defined, otherwise ignored.
serial  output  1  TX line; idle high; registered output.
busy  output  1  a frame is on the wire (start through last stop bit).
idle  output  1  FIFO empty, no frame active, extra stop-bit gap complete.
fifo_count  output  $clog2(fifo_depth+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync-safe deassert by the system):
  - serial=1, busy=0, idle=1, in_ready=1, fifo_count=0.
  - FIFO flushed; state=IDLE; bit_delay=0.
- Reset mid-frame: serial returns to 1 immediately and the frame is abandoned. No residue is transmitted after release.
- Frame format: start bit (0), data_bits data bits (LSB first), optional parity bit, stop_bits stop bits (1).
  - Every bit is held exactly cycles_per_bit clocks.
- State machine: IDLE, START, DATA, PARITY, STOP, GAP.
  - Each state is timed by bit_delay (0..cycles_per_bit-1) and bit_index (0..max(data_bits, stop_bits, extra_stop_bits)-1).
- IDLE → START: when the FIFO is non-empty, pop at the rising edge.
  - serial=0 from that edge onward.
  - Push at edge N into an empty FIFO while in IDLE gives serial low after edge N+1.
- START → DATA → (PARITY) → STOP: transition on bit_delay == cycles_per_bit-1.
  - DATA shifts a data_bits-wide register right by one each bit.
- End of the last stop bit:
  - FIFO non-empty: pop and enter START on the same edge. This makes frames back-to-back with no gap.
  - FIFO empty: enter GAP.
- GAP:
  - Holds serial=1 for extra_stop_bits bit times; busy=0, idle=0.
  - If the FIFO becomes non-empty, pop and enter START at the next bit boundary; the gap is abandoned.
  - Once the gap completes, go to IDLE with idle=1.
- in_ready is computed from the registered count: in_ready = (fifo_count != fifo_depth).
  - When the FIFO is full, a push is refused even if a pop occurs on the same edge.
  - On a simultaneous push and pop when not full, the count is unchanged.
- fifo_count and in_ready update on the edge after a push or pop. Pointers wrap modulo fifo_depth.
- Widths: bit_delay is $clog2(cycles_per_bit) bits and must never exceed cycles_per_bit-1.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - A PARITY state follows DATA; the bit sent is the XOR of the data bits, XOR parity_odd.
  - parity_odd is sampled at pop time and latched for the whole frame.
  - Frame length is 1+data_bits+1+stop_bits bits.
- Undefined: no PARITY state, parity_odd is ignored, and frame length is 1+data_bits+stop_bits bits.

Decomposition:
- Package uart_pkg:
  - TX state enum (tx_state_t).
  - Parity-mode constants.
  - A frame-length helper function of (data_bits, stop_bits, parity enable).
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by width and depth, with push/pop/count and an async reset.

Test Plan:
All scenarios use defaults unless stated.
- Single frame: push 8'hA5 once.
  - serial = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks (40 clocks).
  - busy falls at clock 40; idle rises at clock 68.
- Back-to-back: push 8'h55 then 8'h0F on consecutive cycles.
  - Second start bit begins exactly 40 clocks after the first.
  - serial never stays high more than 4 clocks between the frames.
- FIFO full: hold in_valid high for 6 words (8'h01..8'h06) from IDLE.
  - Word 1 is loaded, words 2-5 fill the FIFO, in_ready=0 and fifo_count=4.
  - Word 6 is accepted the cycle after frame 2 starts.
  - All 6 words are transmitted in order.
- Gap interrupt: push a new byte 50 clocks after a lone frame starts (GAP bit 2).
  - Start bit begins at clock 52 (next bit boundary); idle never asserts.
- Reset mid-frame: assert reset during data bit 3 with 2 words queued.
  - serial=1 and fifo_count=0 within the same cycle; idle=1.
  - No transmission after release.
- UART_TX_PARITY_EN defined, parity_odd=0, push 8'h07: parity bit=1 and the frame is 11 bits (44 clocks).
  - Repeat with parity_odd=1: parity bit=0.
